ysyx_22040759_axi_wslave: RTL and testbench

- AXI4 write-channel responder (slave). Accepts AW, consumes W beats, drives a single-cycle synchronous memory write port with byte strobes, and returns a B response.
- Sits between the crossbar/SoC-side AXI write channels and on-chip RAM or a peripheral register file.
- Pairs with the core's AXI write initiator in simulation and SoC bring-up.

---
 rtl/ysyx_22040759_axi_wslave_pkg.sv | 22 ++
 rtl/ysyx_22040759_axi_addr_gen.sv | 43 ++++
 rtl/ysyx_22040759_axi_wslave.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22040759_axi_wslave.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040759_axi_wslave_pkg.sv
// Shared AXI encodings for the write-channel responder: burst types,
// response codes and the write-slave state machine states.
package ysyx_22040759_axi_wslave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wslave_state_e;

endpackage

// File: rtl/ysyx_22040759_axi_addr_gen.sv
// Combinational AXI burst next-address generator with a legal-window check
// on the current beat address; shared between write and read responders.
module ysyx_22040759_axi_addr_gen
  import ysyx_22040759_axi_wslave_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0800_0000
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              in_range
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W:0]   window_end;

  always_comb begin
    step       = ADDR_W'(1) << size;
    size_mask  = step - ADDR_W'(1);
    // WRAP legality (power-of-two beat count) is enforced upstream, so the
    // wrap container is always a power of two here.
    wrap_mask  = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    window_end = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
    in_range   = ({1'b0, cur_addr} >= {1'b0, ADDR_BASE}) &&
                 ({1'b0, cur_addr} < window_end);

    next_addr = cur_addr;
    case (burst)
      BURST_INCR: next_addr = (cur_addr & ~size_mask) + step;
      BURST_WRAP: next_addr = (start_addr & ~wrap_mask) |
                              ((cur_addr + step) & wrap_mask);
      default:    next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/ysyx_22040759_axi_wslave.sv
// AXI4 write-channel responder: accepts one burst at a time, drives a
// single-cycle strobed memory write port per beat and returns a B response.
module ysyx_22040759_axi_wslave
  import ysyx_22040759_axi_wslave_pkg::*;
#(
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        AXI_USER_WIDTH = 1,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE      = 32'h8000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_SIZE      = 32'h0800_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        axi_aw_valid_i,
  output logic                        axi_aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
  input  logic [7:0]                  axi_aw_len_i,
  input  logic [2:0]                  axi_aw_size_i,
  input  logic [1:0]                  axi_aw_burst_i,
  input  logic                        axi_w_valid_i,
  output logic                        axi_w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                        axi_w_last_i,
  output logic                        axi_b_valid_o,
  input  logic                        axi_b_ready_i,
  output logic [1:0]                  axi_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_b_user_o,
  output logic                        mem_wen_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_wmask_o
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int LANE_LSB = $clog2(STRB_W);

  wslave_state_e             state_reg, state_next;
  logic [AXI_ADDR_WIDTH-1:0] start_addr_reg;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr_reg;
  logic [AXI_ID_WIDTH-1:0]   id_reg;
  logic [7:0]                len_reg;
  logic [2:0]                size_reg;
  logic [1:0]                burst_reg;
  logic [8:0]                beat_cnt_reg;
  logic                      err_reg;

  logic                      aw_hs, w_hs, b_hs;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic                      cur_in_range;
  logic [8:0]                len_ext;
  logic                      err_init;
  logic                      aw_in_range;
  logic [AXI_ADDR_WIDTH-1:0] aw_size_mask;
  logic [AXI_ADDR_WIDTH:0]   window_end;

  ysyx_22040759_axi_addr_gen #(
    .ADDR_W   (AXI_ADDR_WIDTH),
    .ADDR_BASE(ADDR_BASE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_addr_gen (
    .cur_addr  (cur_addr_reg),
    .start_addr(start_addr_reg),
    .size      (size_reg),
    .len       (len_reg),
    .burst     (burst_reg),
    .next_addr (next_addr),
    .in_range  (cur_in_range)
  );

  // Burst-level errors detectable from AW alone.
  always_comb begin
    window_end   = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
    aw_in_range  = ({1'b0, axi_aw_addr_i} >= {1'b0, ADDR_BASE}) &&
                   ({1'b0, axi_aw_addr_i} < window_end);
    aw_size_mask = (AXI_ADDR_WIDTH'(1) << axi_aw_size_i) - AXI_ADDR_WIDTH'(1);
    err_init     = (axi_aw_burst_i == BURST_RSVD) ||
                   (axi_aw_size_i > 3'(LANE_LSB)) ||
                   !aw_in_range ||
                   ((axi_aw_burst_i == BURST_WRAP) &&
                    (!(axi_aw_len_i inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                     ((axi_aw_addr_i & aw_size_mask) != '0)));
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Ready/valid are gated by rst so a reset asserted mid-burst stops traffic at once.
  always_comb begin
    state_next     = state_reg;
    axi_aw_ready_o = 1'b0;
    axi_w_ready_o  = 1'b0;
    axi_b_valid_o  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        axi_aw_ready_o = !rst;
        if (axi_aw_valid_i) state_next = ST_DATA;
      end
      ST_DATA: begin
        axi_w_ready_o = !rst;
        if (axi_w_valid_i && axi_w_last_i) state_next = ST_RESP;
      end
      ST_RESP: begin
        axi_b_valid_o = !rst;
        if (axi_b_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign aw_hs   = axi_aw_valid_i & axi_aw_ready_o;
  assign w_hs    = axi_w_valid_i & axi_w_ready_o;
  assign b_hs    = axi_b_valid_o & axi_b_ready_i;
  assign len_ext = {1'b0, len_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      start_addr_reg <= '0;
      cur_addr_reg   <= '0;
      id_reg         <= '0;
      len_reg        <= '0;
      size_reg       <= '0;
      burst_reg      <= '0;
      beat_cnt_reg   <= '0;
      err_reg        <= 1'b0;
    end else if (aw_hs) begin
      start_addr_reg <= axi_aw_addr_i;
      cur_addr_reg   <= axi_aw_addr_i;
      id_reg         <= axi_aw_id_i;
      len_reg        <= axi_aw_len_i;
      size_reg       <= axi_aw_size_i;
      burst_reg      <= axi_aw_burst_i;
      beat_cnt_reg   <= '0;
      err_reg        <= err_init;
    end else if (w_hs) begin
      cur_addr_reg <= next_addr;
      if (beat_cnt_reg != 9'h1FF) beat_cnt_reg <= beat_cnt_reg + 9'd1;
      // Out-of-window beat, overrun past len, or early WLAST all poison the burst.
      if (!cur_in_range || (beat_cnt_reg > len_ext) ||
          (axi_w_last_i && (beat_cnt_reg < len_ext)))
        err_reg <= 1'b1;
    end
  end

  assign mem_wen_o    = w_hs && !err_reg && cur_in_range && (beat_cnt_reg <= len_ext);
  assign mem_addr_o   = cur_addr_reg & ~AXI_ADDR_WIDTH'(STRB_W - 1);
  assign mem_wdata_o  = axi_w_data_i;
  assign mem_wmask_o  = axi_w_strb_i;

  assign axi_b_resp_o = err_reg ? RESP_SLVERR : RESP_OKAY;
  assign axi_b_id_o   = id_reg;
  assign axi_b_user_o = '0;

  logic unused_b_hs;
  assign unused_b_hs = b_hs;

endmodule

// File: tb/tb_ysyx_22040759_axi_wslave.sv
// Randomized self-checking bench for the AXI write responder: a burst-level
// reference model predicts every memory write and B response.
module tb_ysyx_22040759_axi_wslave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0800_0000;

  logic        clk, rst;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [3:0]  aw_id;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [0:0]  b_user;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;

  ysyx_22040759_axi_wslave dut (
    .clk(clk), .rst(rst),
    .axi_aw_valid_i(aw_valid), .axi_aw_ready_o(aw_ready), .axi_aw_addr_i(aw_addr),
    .axi_aw_id_i(aw_id), .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size),
    .axi_aw_burst_i(aw_burst),
    .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready), .axi_w_data_i(w_data),
    .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
    .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready), .axi_b_resp_o(b_resp),
    .axi_b_id_o(b_id), .axi_b_user_o(b_user),
    .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wmask_o(mem_wmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: expected beat addresses/enables of the current burst.
  int          phase;   // 0 waiting for AW, 1 taking W, 2 responding
  int          beat_i;
  logic [31:0] exp_addr[32];
  bit          exp_wen[32];
  logic [1:0]  exp_resp;
  logic [3:0]  exp_id;

  logic [31:0] wr_log[$];
  logic [1:0]  last_bresp;
  logic [3:0]  last_bid;

  function automatic bit inwin(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(SIZE));
  endfunction

  task automatic build_model(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int n);
    bit          err;
    logic [31:0] sz, wrap, a, ii;
    sz   = 32'd1 << size;
    wrap = (32'(len) + 32'd1) * sz;
    err  = (burst == 2'b11) || (size > 3'd3) || !inwin(addr) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
           (burst == 2'b10 && (addr % sz) != 0);
    for (int i = 0; i < n; i++) begin
      ii = 32'(i);
      case (burst)
        2'b01:   a = (i == 0) ? addr : (addr / sz) * sz + ii * sz;
        2'b10:   a = (addr / wrap) * wrap + (addr + ii * sz) % wrap;
        default: a = addr;
      endcase
      if (!inwin(a)) err = 1'b1;
      exp_addr[i] = a;
      exp_wen[i]  = !err && (ii <= 32'(len));
      if (i == n - 1 && ii < 32'(len)) err = 1'b1;
      if (ii > 32'(len)) err = 1'b1;
    end
    exp_resp = err ? 2'b10 : 2'b00;
    exp_id   = id;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      phase <= 0;
    end else if (phase == 0 && aw_valid) begin
      phase  <= 1;
      beat_i <= 0;
    end else if (phase == 1 && w_valid) begin
      beat_i <= beat_i + 1;
      if (w_last) phase <= 2;
    end else if (phase == 2 && b_ready) begin
      phase <= 0;
    end
  end

  always @(negedge clk) begin
    bit exp_w;
    chk("aw_ready", aw_ready, phase == 0 && !rst);
    chk("w_ready",  w_ready,  phase == 1 && !rst);
    chk("b_valid",  b_valid,  phase == 2 && !rst);
    chk("b_user",   b_user,   0);
    exp_w = phase == 1 && !rst && w_valid && beat_i < 32 && exp_wen[beat_i];
    chk("mem_wen", mem_wen, exp_w);
    if (exp_w) begin
      chk("mem_addr",  mem_addr,  exp_addr[beat_i] & ~32'd7);
      chk("mem_wdata", mem_wdata, w_data);
      chk("mem_wmask", mem_wmask, w_strb);
    end
    if (mem_wen) wr_log.push_back(mem_addr);
    if (phase == 2 && !rst) begin
      chk("b_resp", b_resp, exp_resp);
      chk("b_id",   b_id,   exp_id);
      if (b_ready && b_valid) begin
        last_bresp = b_resp;
        last_bid   = b_id;
      end
    end
  end

  // which: 0 aw_ready, 1 w_ready, 2 b_valid; returns after the handshaking edge.
  task automatic wait_ready(input int which);
    bit got;
    int cnt;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 200) begin
      @(negedge clk);
      got = (which == 0) ? aw_ready : (which == 1) ? w_ready : b_valid;
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout channel=%0d actual=0 expected=1", which);
    end
  endtask

  task automatic drive_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    aw_addr = addr; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst;
    aw_valid = 1'b1;
  endtask

  task automatic do_w(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      w_valid = 1'b1;
      w_data  = {$urandom, $urandom};
      w_strb  = 8'($urandom);
      w_last  = (i == n - 1);
      wait_ready(1);
      w_valid = 1'b0;
      w_last  = 1'b0;
    end
  endtask

  task automatic do_b(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    b_ready = 1'b1;
    wait_ready(2);
    b_ready = 1'b0;
  endtask

  task automatic txn(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input int n,
                     input bit gaps, input int bhold);
    build_model(addr, id, len, size, burst, n);
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    drive_aw(addr, id, len, size, burst);
    wait_ready(0);
    aw_valid = 1'b0;
    do_w(n, gaps);
    do_b(bhold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr, sz;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          n, r;

    rst = 1'b1; aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    phase = 0; beat_i = 0; exp_resp = 0; exp_id = 0;
    for (int i = 0; i < 32; i++) begin exp_addr[i] = 0; exp_wen[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_aw_ready", aw_ready, 1);
    chk("reset_b_resp", b_resp, 0);
    chk("reset_b_id", b_id, 0);
    @(posedge clk); #1;

    // Single full-width beat
    wr_log.delete();
    txn(32'h8000_0010, 4'd5, 8'd0, 3'd3, 2'b01, 1, 0, 0);
    chk("single_nwr", wr_log.size(), 1);
    chk("single_addr", wr_log[0], 32'h8000_0010);
    chk("single_resp", last_bresp, 2'b00);
    chk("single_bid", last_bid, 4'd5);

    // Narrow byte beat aligns the memory address
    wr_log.delete();
    txn(32'h8000_0003, 4'd1, 8'd0, 3'd0, 2'b01, 1, 0, 0);
    chk("narrow_addr", wr_log[0], 32'h8000_0000);
    chk("narrow_resp", last_bresp, 2'b00);

    // INCR with gaps on W valid
    wr_log.delete();
    txn(32'h8000_0100, 4'd2, 8'd3, 3'd3, 2'b01, 4, 1, 1);
    chk("incr_nwr", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("incr_addr", wr_log[i], 32'h8000_0100 + 32'(i * 8));

    // WRAP order
    wr_log.delete();
    txn(32'h8000_0118, 4'd3, 8'd3, 3'd3, 2'b10, 4, 0, 0);
    chk("wrap_a0", wr_log[0], 32'h8000_0118);
    chk("wrap_a1", wr_log[1], 32'h8000_0100);
    chk("wrap_a2", wr_log[2], 32'h8000_0108);
    chk("wrap_a3", wr_log[3], 32'h8000_0110);
    chk("wrap_resp", last_bresp, 2'b00);

    // Below the window
    wr_log.delete();
    txn(32'h7FFF_FFF8, 4'd4, 8'd1, 3'd3, 2'b01, 2, 0, 0);
    chk("oor_nwr", wr_log.size(), 0);
    chk("oor_resp", last_bresp, 2'b10);

    // Early WLAST on the first beat of len=3
    wr_log.delete();
    txn(32'h8000_0200, 4'd6, 8'd3, 3'd3, 2'b01, 1, 0, 0);
    chk("early_nwr", wr_log.size(), 1);
    chk("early_resp", last_bresp, 2'b10);

    // B held off 5 cycles with the next AW already pending
    build_model(32'h8000_0400, 4'd7, 8'd0, 3'd3, 2'b01, 1);
    drive_aw(32'h8000_0400, 4'd7, 8'd0, 3'd3, 2'b01);
    wait_ready(0);
    do_w(1, 0);
    drive_aw(32'h8000_0408, 4'd8, 8'd0, 3'd3, 2'b01);
    do_b(5);
    chk("hold_bid", last_bid, 4'd7);
    build_model(32'h8000_0408, 4'd8, 8'd0, 3'd3, 2'b01, 1);
    wait_ready(0);
    aw_valid = 1'b0;
    do_w(1, 0);
    do_b(0);
    chk("pend_bid", last_bid, 4'd8);

    // Reset asserted during DATA
    wr_log.delete();
    build_model(32'h8000_0300, 4'd9, 8'd3, 3'd3, 2'b01, 4);
    drive_aw(32'h8000_0300, 4'd9, 8'd3, 3'd3, 2'b01);
    wait_ready(0);
    aw_valid = 1'b0;
    w_valid = 1'b1; w_data = 64'h1122334455667788; w_strb = 8'hFF; w_last = 1'b0;
    wait_ready(1);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_mid_b_id", b_id, 0);
    chk("rst_mid_b_resp", b_resp, 0);
    chk("rst_mid_wen", mem_wen, 0);
    @(posedge clk); #1;
    rst = 1'b0; w_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_nwr", wr_log.size(), 1);

    // Randomized bursts
    for (int t = 0; t < 60; t++) begin
      r = $urandom % 8;
      burst = (r == 0) ? 2'b00 : (r <= 4) ? 2'b01 : (r <= 6) ? 2'b10 : 2'b11;
      size  = ($urandom % 10 < 9) ? 3'($urandom % 4) : 3'(4 + $urandom % 4);
      if (burst == 2'b10 && $urandom % 5 != 0) len = 8'((2 << ($urandom % 4)) - 1);
      else len = 8'($urandom % 16);
      r = $urandom % 6;
      if (r < 4)      addr = BASE + ($urandom % 4096);
      else if (r < 5) addr = BASE + SIZE - ($urandom % 64 + 1);
      else            addr = BASE - ($urandom % 64 + 1);
      sz = 32'd1 << size;
      if (burst == 2'b10 && $urandom % 4 != 0) addr = addr & ~(sz - 1);
      r = $urandom % 8;
      if (r < 6)       n = int'(len) + 1;
      else if (r == 6) n = $urandom_range(1, int'(len) + 1);
      else             n = int'(len) + 1 + $urandom_range(1, 3);
      txn(addr, 4'($urandom), len, size, burst, n, 1'($urandom), $urandom % 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
